axi_4_master_arbiter: RTL and testbench
=======================================

# axi_4_master_arbiter

Shares the single AXI4 master controller between `NUM_REQ` load/store requesters, e.g. the vector LSU and a scalar LSU or prefetcher. It picks one requester and issues its load or store request to the master controller as a one-cycle pulse. It then holds the grant until the transaction completes on the AXI read-data or write-response channel. The grant outputs also steer the address/data muxes in front of the AXI master datapath.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (2..8).
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_ld` in `NUM_REQ`: per-requester load request; level, held until `done`.
- `req_st` in `NUM_REQ`: per-requester store request; level, held until `done`.
- `gnt` out `NUM_REQ`: one-hot grant; all-zero when idle.
- `gnt_idx` out `IDX_W`: binary index of granted requester; 0 when idle.
- `done` out `NUM_REQ`: one-cycle pulse to the granted requester on completion.
- `busy` out 1: high from grant through completion.
- `ld_req` out 1: to master controller; one-cycle load pulse.
- `st_req` out 1: to master controller; one-cycle store pulse.
- `s_rvalid`, `m_rready`, `s_rlast` in 1 each: read-data channel snoop.
- `s_bvalid`, `m_bready` in 1 each: write-response channel snoop.

## Operation
- States (`axi_4_arb_states_e`): `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT_R`, `ARB_WAIT_B`.
- Eligible set: requesters where `req_ld | req_st` is high, excluding any requester whose `done` is high this cycle. The requester sees `done` and drops its request the next cycle, so it is never re-granted on the same request.
- `ARB_IDLE`:
  - If the eligible set is non-empty, pick one requester.
  - Register `gnt`, `gnt_idx`, and the direction: load wins if both `req_ld[i]` and `req_st[i]` are high.
  - Go to `ARB_ISSUE`.
- `ARB_ISSUE`:
  - Drive `ld_req` or `st_req` high for exactly this one cycle.
  - Go to `ARB_WAIT_R` for a load, `ARB_WAIT_B` for a store.
- `ARB_WAIT_R`: leave when `s_rvalid & m_rready & s_rlast`.
- `ARB_WAIT_B`: leave when `s_bvalid & m_bready`.
- On completion:
  - Next state is `ARB_IDLE`; `gnt` clears.
  - `done[gnt_idx]` is registered high for one cycle, i.e. the cycle the FSM is back in `ARB_IDLE`.
  - The round-robin pointer updates to `gnt_idx + 1`, wrapping from `NUM_REQ-1` to 0.
- Request inputs are ignored outside `ARB_IDLE`.
- A requester that drops its request while granted does not abort the transaction. The grant stays until AXI completion.
- `busy` = state != `ARB_IDLE`.

## Timing
- Reset values: `gnt`=0, `gnt_idx`=0, `done`=0, `busy`=0, `ld_req`=0, `st_req`=0; state `ARB_IDLE`; pointer 0.
- `reset` asserted mid-transaction returns everything to reset values on the next edge. The master controller must be reset in the same cycle.
- Request-to-issue latency:
  - Request sampled in `ARB_IDLE` at cycle 0.
  - `gnt` valid and `ld_req`/`st_req` pulse in cycle 1.
  - The controller accepts the pulse in its idle state in cycle 1.
- Completion-to-next-issue:
  - Completion handshake in cycle N.
  - `ARB_IDLE` and `done` in N+1; next grant registered at the end of N+1.
  - Next pulse in N+2.
  - This matches the controller returning to idle at N+1.
- Exactly one `ld_req`/`st_req` pulse per grant, and never both.
- Completion snoop strobes seen in `ARB_ISSUE` are ignored; completion cannot occur before the address phase.

## Configuration
- `AXI4_ARB_RR_EN` defined: round-robin pick. Search starts at the pointer and takes the first eligible index upward, wrapping.
- Undefined: fixed priority; lowest eligible index wins, and the pointer register is not built.
- All other behaviour is identical in both builds.

## Structure
- Shared defs header holds:
  - `axi_4_arb_states_e`.
  - `AXI4_ARB_MAX_REQ` = 8, used as the parameter range check.
- One sub-module, `axi_4_arb_picker`: combinational masked priority picker.
  - Inputs: eligible vector and start pointer.
  - Outputs: one-hot grant and index.
  - With `AXI4_ARB_RR_EN` undefined, instantiate it with the pointer tied to 0.
- FSM, grant/direction registers, pointer and `done` register live in `axi_4_master_arbiter`.

## Test plan
- **Single load:**
  - Stimulus: `req_ld`=01 at cycle 0; `s_rvalid & m_rready & s_rlast` at cycle 6.
  - Response: `gnt`=01 and `ld_req`=1 in cycle 1 only; `done`=01 in cycle 7; `busy` low in cycle 7.
- **Load/store tie on one requester:** `req_ld[1]`=`req_st[1]`=1 → `ld_req` pulses, `st_req` never does, FSM enters `ARB_WAIT_R`.
- **Round-robin** (`AXI4_ARB_RR_EN`):
  - Stimulus: both requesters hold requests for 4 transactions.
  - Response with RR: grants 0,1,0,1.
  - Response with macro undefined: grants 0,0,0,0 while `req[0]` is re-raised each time.
- **Back-to-back store then load:**
  - Stimulus: `req_st`=01, `req_ld`=10; `bvalid & bready` at cycle N.
  - Response: `done`=01 at N+1; `gnt`=10 with `ld_req` at N+2.
- **Reset mid-transaction:** `reset`=1 during `ARB_WAIT_B` → next cycle all outputs 0, `ARB_IDLE`, pointer 0, no `done` pulse.
- **Requester drops request while granted:** grant held, no second pulse, `done` still issued on `bvalid & bready`.

Source files
------------

// File: rtl/axi_4_master_arbiter_pkg.sv
// Shared definitions for the AXI4 master arbiter: FSM state encoding and
// the upper bound on the number of requesters.
package axi_4_master_arbiter_pkg;

    localparam int AXI4_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_WAIT_R = 2'd2,
        ARB_WAIT_B = 2'd3
    } axi_4_arb_states_e;

endpackage

// File: rtl/axi_4_master_arbiter_if.sv
// Bundle of requester handshakes, grant outputs, controller pulses and the
// AXI read-data / write-response snoop strobes around the arbiter.
// master modport: the arbiter side. slave modport: requesters + AXI side.
interface axi_4_master_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0] req_ld;
    logic [NUM_REQ-1:0] req_st;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] done;
    logic               busy;
    logic               ld_req;
    logic               st_req;
    logic               s_rvalid;
    logic               m_rready;
    logic               s_rlast;
    logic               s_bvalid;
    logic               m_bready;

    modport master (
        input  req_ld, req_st, s_rvalid, m_rready, s_rlast, s_bvalid, m_bready,
        output gnt, gnt_idx, done, busy, ld_req, st_req
    );

    modport slave (
        output req_ld, req_st, s_rvalid, m_rready, s_rlast, s_bvalid, m_bready,
        input  gnt, gnt_idx, done, busy, ld_req, st_req
    );

endinterface

// File: rtl/axi_4_master_arbiter_picker.sv
// axi_4_arb_picker: combinational masked priority picker. Starting at
// i_ptr, returns the first eligible requester searching upward with wrap.
// A pointer tied to zero gives plain lowest-index-wins priority.
module axi_4_arb_picker
    import axi_4_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Rotating scan from the pointer; the first hit wins.
    always_comb begin : p_pick
        int unsigned v_pos;
        logic [IDX_W-1:0] v_idx;
        logic w_found;
        o_gnt   = '0;
        o_idx   = '0;
        v_pos   = 0;
        v_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_pos = 32'(i_ptr) + k;
            if (v_pos >= NUM_REQ) begin
                v_pos = v_pos - NUM_REQ;
            end
            v_idx = IDX_W'(v_pos);
            if (!w_found && i_elig[v_idx]) begin
                w_found      = 1'b1;
                o_gnt[v_idx] = 1'b1;
                o_idx        = v_idx;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/axi_4_master_arbiter.sv
// axi_4_master_arbiter: shares one AXI4 master controller between NUM_REQ
// load/store requesters. Grants one requester, pulses ld_req/st_req for one
// cycle, and holds the grant until the read-data last beat or the write
// response completes.
// Build option: define AXI4_ARB_RR_EN for round-robin selection; otherwise
// fixed priority (lowest index wins) and no pointer register is built.
module axi_4_master_arbiter
    import axi_4_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_4_master_arbiter_if.master io_bus
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > AXI4_ARB_MAX_REQ) begin : g_bad_num_req
            $error("axi_4_master_arbiter: NUM_REQ out of range 2..8");
        end
    endgenerate

    axi_4_arb_states_e  r_state;
    axi_4_arb_states_e  w_next;

    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_is_ld;
    logic [NUM_REQ-1:0] r_done;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [IDX_W-1:0]   w_ptr;
    logic               w_r_hs;
    logic               w_b_hs;
    logic               w_complete;
    logic               w_ld_req;
    logic               w_st_req;
    logic               w_busy;

    // A requester seeing done this cycle still has its request up; mask it
    // so the same request is never granted twice.
    assign w_elig     = (io_bus.req_ld | io_bus.req_st) & ~r_done;
    assign w_r_hs     = io_bus.s_rvalid & io_bus.m_rready & io_bus.s_rlast;
    assign w_b_hs     = io_bus.s_bvalid & io_bus.m_bready;
    assign w_complete = ((r_state == ARB_WAIT_R) && w_r_hs) ||
                        ((r_state == ARB_WAIT_B) && w_b_hs);

`ifdef AXI4_ARB_RR_EN
    logic [IDX_W-1:0] r_ptr;

    // Round-robin pointer: one past the requester that just completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_complete) begin
            if (32'(r_gnt_idx) == NUM_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_gnt_idx + IDX_W'(1);
            end
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    axi_4_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_elig (w_elig),
        .i_ptr  (w_ptr),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: snoop strobes only count in the matching wait state.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ARB_IDLE:   if (w_pick_any) w_next = ARB_ISSUE;
            ARB_ISSUE:  w_next = r_is_ld ? ARB_WAIT_R : ARB_WAIT_B;
            ARB_WAIT_R: if (w_r_hs) w_next = ARB_IDLE;
            ARB_WAIT_B: if (w_b_hs) w_next = ARB_IDLE;
            default:    w_next = ARB_IDLE;
        endcase
    end

    // FSM outputs: single controller pulse in ARB_ISSUE, busy outside idle.
    always_comb begin
        w_ld_req = 1'b0;
        w_st_req = 1'b0;
        w_busy   = (r_state != ARB_IDLE);
        if (r_state == ARB_ISSUE) begin
            w_ld_req = r_is_ld;
            w_st_req = ~r_is_ld;
        end
    end

    // Grant and direction capture in idle; cleared on AXI completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_is_ld   <= 1'b0;
        end else if ((r_state == ARB_IDLE) && w_pick_any) begin
            r_gnt     <= w_pick_gnt;
            r_gnt_idx <= w_pick_idx;
            r_is_ld   <= |(io_bus.req_ld & w_pick_gnt);
        end else if (w_complete) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
        end
    end

    // One-cycle done pulse to the requester that held the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= '0;
        end else begin
            r_done <= w_complete ? r_gnt : '0;
        end
    end

    assign io_bus.gnt     = r_gnt;
    assign io_bus.gnt_idx = r_gnt_idx;
    assign io_bus.done    = r_done;
    assign io_bus.busy    = w_busy;
    assign io_bus.ld_req  = w_ld_req;
    assign io_bus.st_req  = w_st_req;

endmodule

// File: tb/tb_axi_4_master_arbiter.sv
// Scoreboard bench for axi_4_master_arbiter with two requesters. The
// stimulus pushes expected snapshots, issue pulses and done pulses into
// queues; a negedge monitor pops and compares them as the DUT presents them.
// Expected grant order in the arbitration test depends on AXI4_ARB_RR_EN.
module tb_axi_4_master_arbiter;

    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic [1:0] gnt;
        logic       idx;
        logic [1:0] done;
        logic       busy;
        logic       ld;
        logic       st;
    } snap_t;

    typedef struct packed {
        logic [1:0] gnt;
        logic       idx;
        logic       ld;
        logic       st;
    } iss_t;

    logic clk;
    logic reset;

    axi_4_master_arbiter_if #(.NUM_REQ(NUM_REQ)) u_if ();

    axi_4_master_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (u_if.master)
    );

    snap_t      q_snap[$];
    iss_t       q_iss[$];
    logic [1:0] q_done[$];
    bit         stim_done;
    int         n_checks;
    int         n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic exp_snap(input logic [1:0] g, input logic i, input logic [1:0] d,
                            input logic b, input logic ld, input logic st);
        q_snap.push_back('{gnt: g, idx: i, done: d, busy: b, ld: ld, st: st});
    endtask

    task automatic exp_idle;
        exp_snap(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_iss(input logic [1:0] g, input logic i, input logic ld);
        q_iss.push_back('{gnt: g, idx: i, ld: ld, st: ~ld});
    endtask

    task automatic set_r(input logic v);
        u_if.s_rvalid = v;
        u_if.m_rready = v;
        u_if.s_rlast  = v;
    endtask

    task automatic set_b(input logic v);
        u_if.s_bvalid = v;
        u_if.m_bready = v;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin : p_mon
        snap_t      a_snap;
        snap_t      e_snap;
        iss_t       a_iss;
        iss_t       e_iss;
        logic [1:0] e_done;
        a_snap = '{gnt: u_if.gnt, idx: u_if.gnt_idx, done: u_if.done,
                   busy: u_if.busy, ld: u_if.ld_req, st: u_if.st_req};
        a_iss  = '{gnt: u_if.gnt, idx: u_if.gnt_idx, ld: u_if.ld_req, st: u_if.st_req};
        if (q_snap.size() > 0) begin
            e_snap = q_snap.pop_front();
            n_checks++;
            if (a_snap !== e_snap) begin
                n_errors++;
                $display("FAIL snapshot @%0t: got gnt=%b idx=%b done=%b busy=%b ld=%b st=%b, want gnt=%b idx=%b done=%b busy=%b ld=%b st=%b",
                         $time, a_snap.gnt, a_snap.idx, a_snap.done, a_snap.busy, a_snap.ld, a_snap.st,
                         e_snap.gnt, e_snap.idx, e_snap.done, e_snap.busy, e_snap.ld, e_snap.st);
            end
        end
        if (u_if.ld_req || u_if.st_req) begin
            n_checks++;
            if (q_iss.size() == 0) begin
                n_errors++;
                $display("FAIL issue @%0t: unexpected pulse gnt=%b idx=%b ld=%b st=%b, want none",
                         $time, a_iss.gnt, a_iss.idx, a_iss.ld, a_iss.st);
            end else begin
                e_iss = q_iss.pop_front();
                if (a_iss !== e_iss) begin
                    n_errors++;
                    $display("FAIL issue @%0t: got gnt=%b idx=%b ld=%b st=%b, want gnt=%b idx=%b ld=%b st=%b",
                             $time, a_iss.gnt, a_iss.idx, a_iss.ld, a_iss.st,
                             e_iss.gnt, e_iss.idx, e_iss.ld, e_iss.st);
                end
            end
        end
        if (u_if.done !== 2'b00) begin
            n_checks++;
            if (q_done.size() == 0) begin
                n_errors++;
                $display("FAIL done @%0t: unexpected done=%b, want none", $time, u_if.done);
            end else begin
                e_done = q_done.pop_front();
                if (u_if.done !== e_done) begin
                    n_errors++;
                    $display("FAIL done @%0t: got done=%b, want %b", $time, u_if.done, e_done);
                end
            end
        end
        if (stim_done) begin
            n_checks++;
            if (q_snap.size() != 0 || q_iss.size() != 0 || q_done.size() != 0) begin
                n_errors++;
                $display("FAIL drain: got %0d/%0d/%0d pending snap/issue/done, want 0/0/0",
                         q_snap.size(), q_iss.size(), q_done.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    // Stimulus.
    initial begin : p_stim
        logic [1:0] g;
        logic       gi;
        logic       rr_idx[4];
`ifdef AXI4_ARB_RR_EN
        rr_idx = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        rr_idx = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        stim_done   = 1'b0;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        u_if.req_ld = '0;
        u_if.req_st = '0;
        set_r(1'b0);
        set_b(1'b0);

        // Reset state.
        ticks(2);
        exp_idle();
        tick();
        reset = 1'b0;
        exp_idle();
        tick();

        // Single load: request c0, pulse c1, last beat c6, done c7.
        u_if.req_ld = 2'b01;
        exp_idle();
        tick();
        exp_iss(2'b01, 1'b0, 1'b1);
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        ticks(4);
        set_r(1'b1);
        q_done.push_back(2'b01);
        tick();
        set_r(1'b0);
        exp_snap(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        u_if.req_ld = '0;
        exp_idle();
        tick();

        // Load/store tie on requester 1; early and wrong-channel strobes ignored.
        u_if.req_ld = 2'b10;
        u_if.req_st = 2'b10;
        exp_idle();
        tick();
        exp_iss(2'b10, 1'b1, 1'b1);
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        set_r(1'b1);
        tick();
        set_r(1'b0);
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        set_b(1'b1);
        tick();
        set_b(1'b0);
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        u_if.s_rvalid = 1'b1;
        u_if.m_rready = 1'b1;
        tick();
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        u_if.s_rlast = 1'b1;
        q_done.push_back(2'b10);
        tick();
        set_r(1'b0);
        exp_snap(2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        u_if.req_ld = '0;
        u_if.req_st = '0;
        exp_idle();
        tick();

        // Back-to-back: store on 0, then load on 1 two cycles after bvalid.
        u_if.req_st = 2'b01;
        u_if.req_ld = 2'b10;
        exp_idle();
        tick();
        exp_iss(2'b01, 1'b0, 1'b0);
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        set_b(1'b1);
        q_done.push_back(2'b01);
        tick();
        set_b(1'b0);
        exp_snap(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        u_if.req_st = '0;
        exp_iss(2'b10, 1'b1, 1'b1);
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        set_r(1'b1);
        q_done.push_back(2'b10);
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        set_r(1'b0);
        exp_snap(2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        u_if.req_ld = '0;
        exp_idle();
        tick();

        // Requester drops its store request while granted.
        u_if.req_st = 2'b01;
        exp_idle();
        tick();
        u_if.req_st = '0;
        exp_iss(2'b01, 1'b0, 1'b0);
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        exp_snap(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        set_b(1'b1);
        q_done.push_back(2'b01);
        tick();
        set_b(1'b0);
        exp_snap(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        exp_idle();
        tick();

        // Reset during ARB_WAIT_B, coinciding with bvalid: no done pulse.
        u_if.req_st = 2'b10;
        exp_idle();
        tick();
        exp_iss(2'b10, 1'b1, 1'b0);
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        exp_snap(2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        reset       = 1'b1;
        u_if.req_st = '0;
        set_b(1'b1);
        tick();
        reset = 1'b0;
        set_b(1'b0);
        exp_idle();
        tick();
        exp_idle();
        tick();

        // Arbitration order: both raise together, drop on done, four rounds.
        for (int r = 0; r < 4; r++) begin
            gi     = rr_idx[r];
            g      = '0;
            g[gi]  = 1'b1;
            u_if.req_ld = 2'b11;
            exp_idle();
            tick();
            exp_iss(g, gi, 1'b1);
            exp_snap(g, gi, 2'b00, 1'b1, 1'b1, 1'b0);
            tick();
            set_r(1'b1);
            q_done.push_back(g);
            tick();
            set_r(1'b0);
            u_if.req_ld = '0;
            exp_snap(2'b00, 1'b0, g, 1'b0, 1'b0, 1'b0);
            tick();
        end

        exp_idle();
        tick();
        stim_done = 1'b1;
    end

endmodule
